// File: rtl/counter_checker.sv
// counter_checker: protocol monitor for the up/down/load counter.
// It keeps a reference model of the counter, compares the counter's Q and
// rco against that model on every clock edge, and reports any mismatch.
//
// Ports:
//   clk, reset    - rising-edge clock; synchronous active-high reset
//   enb, modo, D  - counter controls, exactly as driven to the counter
//   Q, rco        - counter outputs under observation
//   synced        - model is anchored (TRACK or HALT)
//   err           - one-cycle pulse on any mismatch
//   err_q/err_rco - one-cycle pulses for the Q and rco mismatch cases
//   err_sticky    - set on the first mismatch, cleared only by reset
//   err_count     - saturating count of mismatching edges
//   check_count   - saturating count of compared edges
//   exp_Q         - current model value of Q
module counter_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             rco,
  output logic             synced,
  output logic             err,
  output logic             err_q,
  output logic             err_rco,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic [WIDTH-1:0] exp_Q
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t           state;
  logic             exp_rco;
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_rco;
  logic             mis_q;
  logic             mis_rco;
  logic             mis_any;

  // Next model value, computed from the controls sampled at this edge.
  always_comb begin
    nxt_q   = exp_Q;
    nxt_rco = 1'b0;
    if (enb) begin
      case (modo)
        2'b00: begin
          nxt_q   = exp_Q + WIDTH'(1);
          nxt_rco = (exp_Q == '1);
        end
        2'b01: begin
          nxt_q   = exp_Q - WIDTH'(1);
          nxt_rco = (exp_Q == '0);
        end
        2'b10: begin
          nxt_q   = exp_Q - WIDTH'(3);
          nxt_rco = (exp_Q < WIDTH'(3));
        end
        default: begin
          nxt_q   = D;
          nxt_rco = 1'b0;
        end
      endcase
    end
  end

  // Case inequality so an unknown Q or rco is reported as a mismatch.
  assign mis_q   = (Q !== exp_Q);
  assign mis_rco = (rco !== exp_rco);
  assign mis_any = mis_q | mis_rco;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= UNSYNC;
      synced      <= 1'b0;
      err         <= 1'b0;
      err_q       <= 1'b0;
      err_rco     <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      check_count <= '0;
      exp_Q       <= '0;
      exp_rco     <= 1'b0;
    end else begin
      err     <= 1'b0;
      err_q   <= 1'b0;
      err_rco <= 1'b0;
      case (state)
        UNSYNC: begin
          if (enb && (modo == 2'b11)) begin
            exp_Q   <= D;
            exp_rco <= 1'b0;
            state   <= TRACK;
            synced  <= 1'b1;
          end
        end
        TRACK: begin
          if (check_count != '1)
            check_count <= check_count + CNT_W'(1);
          if (mis_any) begin
            err        <= 1'b1;
            err_q      <= mis_q;
            err_rco    <= mis_rco;
            err_sticky <= 1'b1;
            if (err_count != '1)
              err_count <= err_count + CNT_W'(1);
            if (STOP_ON_ERR)
              state <= HALT;
          end
          // The model always advances from its own value, never from Q.
          exp_Q   <= nxt_q;
          exp_rco <= nxt_rco;
        end
        HALT: begin
        end
        default: begin
          state  <= UNSYNC;
          synced <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a behavioural counter drives Q/rco, with
// optional fault overrides; two checkers (STOP_ON_ERR 0 and 1) watch it.
module tb_counter_checker;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int M  = 1 << W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enb = 1'b0;
  logic [1:0]    modo = 2'b00;
  logic [W-1:0]  d = '0;
  logic          qf_en = 1'b0;
  logic [W-1:0]  qf_val = '0;
  logic          rco_kill = 1'b0;

  int            cnt_q = 0;
  bit            cnt_rco = 1'b0;
  logic [W-1:0]  q_drv;
  logic          rco_drv;

  assign q_drv   = qf_en ? qf_val : W'(cnt_q);
  assign rco_drv = cnt_rco & ~rco_kill;

  logic          synced_o  [2];
  logic          err_o     [2];
  logic          errq_o    [2];
  logic          errr_o    [2];
  logic          sticky_o  [2];
  logic [CW-1:0] errc_o    [2];
  logic [CW-1:0] chk_o     [2];
  logic [W-1:0]  expq_o    [2];

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(W), .CNT_W(CW), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(d), .Q(q_drv), .rco(rco_drv),
    .synced(synced_o[0]), .err(err_o[0]), .err_q(errq_o[0]), .err_rco(errr_o[0]),
    .err_sticky(sticky_o[0]), .err_count(errc_o[0]), .check_count(chk_o[0]), .exp_Q(expq_o[0])
  );

  counter_checker #(.WIDTH(W), .CNT_W(CW), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(d), .Q(q_drv), .rco(rco_drv),
    .synced(synced_o[1]), .err(err_o[1]), .err_q(errq_o[1]), .err_rco(errr_o[1]),
    .err_sticky(sticky_o[1]), .err_count(errc_o[1]), .check_count(chk_o[1]), .exp_Q(expq_o[1])
  );

  // Counter rules: returns the value and carry after one edge.
  function automatic void next_val(input int q, input bit e, input int m, input int dd,
                                   output int nq, output bit nr);
    nq = q;
    nr = 1'b0;
    if (e) begin
      case (m)
        0: begin nq = (q + 1) % M;     nr = (q == M - 1); end
        1: begin nq = (q + M - 1) % M; nr = (q == 0);     end
        2: begin nq = (q + M - 3) % M; nr = (q < 3);      end
        default: begin nq = dd;        nr = 1'b0;         end
      endcase
    end
  endfunction

  // Checker model: phase 0 = waiting for a load, 1 = checking, 2 = halted.
  int  m_phase [2];
  int  m_exp   [2];
  bit  m_exprco[2];
  bit  m_err   [2];
  bit  m_eq    [2];
  bit  m_er    [2];
  bit  m_stk   [2];
  int  m_errc  [2];
  int  m_chk   [2];
  bit  model_ok = 1'b0;

  always @(posedge clk) begin : model
    int nq;
    bit nr;
    bit mq;
    bit mr;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0; m_exp[i] = 0; m_exprco[i] = 0;
        m_err[i] = 0; m_eq[i] = 0; m_er[i] = 0; m_stk[i] = 0;
        m_errc[i] = 0; m_chk[i] = 0;
      end else begin
        m_err[i] = 0; m_eq[i] = 0; m_er[i] = 0;
        if (m_phase[i] == 0) begin
          if (enb && modo == 2'b11) begin
            m_exp[i] = int'(d); m_exprco[i] = 0; m_phase[i] = 1;
          end
        end else if (m_phase[i] == 1) begin
          mq = (q_drv !== W'(m_exp[i]));
          mr = (rco_drv !== m_exprco[i]);
          m_chk[i] = (m_chk[i] < 255) ? m_chk[i] + 1 : 255;
          if (mq || mr) begin
            m_err[i] = 1; m_eq[i] = mq; m_er[i] = mr; m_stk[i] = 1;
            m_errc[i] = (m_errc[i] < 255) ? m_errc[i] + 1 : 255;
            if (i == 1) m_phase[i] = 2;
          end
          next_val(m_exp[i], enb, int'(modo), int'(d), nq, nr);
          m_exp[i] = nq;
          m_exprco[i] = nr;
        end
      end
    end
    if (reset) model_ok = 1'b1;
    if (reset) begin
      cnt_q   <= 0;
      cnt_rco <= 1'b0;
    end else begin
      next_val(cnt_q, enb, int'(modo), int'(d), nq, nr);
      cnt_q   <= nq;
      cnt_rco <= nr;
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h, want %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        chk("synced", i, 32'(synced_o[i]), 32'(m_phase[i] != 0));
        chk("err", i, 32'(err_o[i]), 32'(m_err[i]));
        chk("err_q", i, 32'(errq_o[i]), 32'(m_eq[i]));
        chk("err_rco", i, 32'(errr_o[i]), 32'(m_er[i]));
        chk("err_sticky", i, 32'(sticky_o[i]), 32'(m_stk[i]));
        chk("err_count", i, 32'(errc_o[i]), 32'(m_errc[i]));
        chk("check_count", i, 32'(chk_o[i]), 32'(m_chk[i]));
        chk("exp_Q", i, 32'(expq_o[i]), 32'(m_exp[i]));
      end
    end
  end

  // Drive one edge's inputs at a falling edge, return after the next one.
  task automatic tick(input bit e, input int m, input int dd,
                      input bit fe = 1'b0, input int fv = 0, input bit rk = 1'b0);
    enb = e; modo = 2'(m); d = W'(dd);
    qf_en = fe; qf_val = W'(fv); rco_kill = rk;
    @(negedge clk);
    qf_en = 1'b0; rco_kill = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enb = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_synced", 0, 32'(synced_o[0]), 0);
    chk("rst_chk", 0, 32'(chk_o[0]), 0);

    // 1: load 5 then count up three times
    tick(1, 3, 5);
    repeat (3) tick(1, 0, 0);
    chk("t1_chk", 0, 32'(chk_o[0]), 3);
    chk("t1_errc", 0, 32'(errc_o[0]), 0);
    chk("t1_expq", 0, 32'(expq_o[0]), 8);

    // 2: wrap from F with carry, then a missing carry
    do_reset();
    tick(1, 3, 15);
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("t2_clean_err", 0, 32'(err_o[0]), 0);
    chk("t2_clean_errc", 0, 32'(errc_o[0]), 0);
    tick(1, 3, 15);
    tick(1, 0, 0);
    tick(1, 0, 0, 1'b0, 0, 1'b1);
    chk("t2_err", 0, 32'(err_o[0]), 1);
    chk("t2_err_rco", 0, 32'(errr_o[0]), 1);
    chk("t2_err_q", 0, 32'(errq_o[0]), 0);
    chk("t2_errc", 0, 32'(errc_o[0]), 1);
    chk("t2_sticky", 0, 32'(sticky_o[0]), 1);
    tick(1, 0, 0);
    chk("t2_pulse_end", 0, 32'(err_o[0]), 0);
    chk("t2_sticky_hold", 0, 32'(sticky_o[0]), 1);

    // 3: minus-3 and minus-1 across zero, then a wrong Q
    do_reset();
    tick(1, 3, 1);
    tick(1, 2, 0);
    chk("t3_expq_E", 0, 32'(expq_o[0]), 32'hE);
    tick(1, 1, 0);
    chk("t3_expq_D", 0, 32'(expq_o[0]), 32'hD);
    tick(1, 0, 0, 1'b1, 12);
    chk("t3_err_q", 0, 32'(errq_o[0]), 1);
    chk("t3_err_rco", 0, 32'(errr_o[0]), 0);
    chk("t3_expq_cont", 0, 32'(expq_o[0]), 32'hE);
    tick(1, 0, 0);
    chk("t3_no_err", 0, 32'(err_o[0]), 0);
    chk("t3_errc", 0, 32'(errc_o[0]), 1);

    // 4: enable low for four edges
    do_reset();
    tick(1, 3, 9);
    for (int k = 0; k < 4; k++) tick(0, k, 0);
    chk("t4_chk", 0, 32'(chk_o[0]), 4);
    chk("t4_expq", 0, 32'(expq_o[0]), 9);
    chk("t4_errc", 0, 32'(errc_o[0]), 0);

    // 5: stop-on-error checker halts
    do_reset();
    tick(1, 3, 3);
    repeat (2) tick(1, 0, 0);
    tick(1, 0, 0, 1'b1, 0);
    chk("t5_err", 1, 32'(err_o[1]), 1);
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 0, 1'b1, 0);
      chk("t5_chk", 1, 32'(chk_o[1]), 3);
      chk("t5_errc", 1, 32'(errc_o[1]), 1);
      chk("t5_err_off", 1, 32'(err_o[1]), 0);
      chk("t5_synced", 1, 32'(synced_o[1]), 1);
      chk("t5_expq", 1, 32'(expq_o[1]), 6);
    end

    // 6: reset mid-track, count without load, then reload
    do_reset();
    tick(1, 3, 2);
    repeat (2) tick(1, 0, 0);
    reset = 1'b1;
    tick(1, 0, 0);
    reset = 1'b0;
    repeat (3) tick(1, 0, 0);
    chk("t6_synced", 0, 32'(synced_o[0]), 0);
    chk("t6_chk", 0, 32'(chk_o[0]), 0);
    chk("t6_err", 0, 32'(err_o[0]), 0);
    tick(1, 3, 7);
    chk("t6_resync", 0, 32'(synced_o[0]), 1);
    chk("t6_chk0", 0, 32'(chk_o[0]), 0);
    tick(1, 0, 0);
    chk("t6_chk1", 0, 32'(chk_o[0]), 1);
    chk("t6_errc", 0, 32'(errc_o[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
Synthesizable protocol monitor that watches the counter interface (enb, modo, D, Q, rco) from the consuming side. It keeps its own reference model of the counter, compares the DUT's Q and rco on every clock edge, and reports mismatches through pulse, sticky and count outputs. It sits beside the counter in benches and system builds and works with both the 4-bit and 16-bit counters via WIDTH.

Parameters:
WIDTH, 4, counter data width (D, Q, exp_Q).
CNT_W, 8, width of err_count and check_count.
STOP_ON_ERR, 0, when 1 the first mismatch moves the FSM to HALT.

Ports:
clk  input  1  rising-edge clock, shared with the counter.
reset  input  1  synchronous, active-high reset.
enb  input  1  counter enable, as driven to the DUT.
modo  input  2  counter mode, as driven to the DUT.
D  input  WIDTH  counter load data, as driven to the DUT.
Q  input  WIDTH  DUT count output.
rco  input  1  DUT ripple-carry output.
synced  output  1  high while the FSM is in TRACK or HALT.
err  output  1  one-cycle pulse on any mismatch.
err_q  output  1  one-cycle pulse when Q mismatches.
err_rco  output  1  one-cycle pulse when rco mismatches.
err_sticky  output  1  set on the first mismatch, cleared only by reset.
err_count  output  CNT_W  number of mismatching edges, saturating.
check_count  output  CNT_W  number of compared edges, saturating.
exp_Q  output  WIDTH  current model value of Q.

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous, active-high, and has priority over all other inputs.
- Reset values: FSM=UNSYNC, synced=0, err=err_q=err_rco=0, err_sticky=0, err_count=0, check_count=0, exp_Q=0, internal exp_rco=0.
- Counter semantics modelled (mod 2^WIDTH):
  - enb=0: Q holds, rco=0.
  - modo=00: Q+1; rco=1 when old Q = all-ones.
  - modo=01: Q-1; rco=1 when old Q = 0.
  - modo=10: Q-3; rco=1 when old Q < 3.
  - modo=11: load D; rco=0.
  - The DUT registers Q and rco on the same edge.
- FSM states:
  - UNSYNC: no compares. An edge with enb=1 and modo=11 sets exp_Q<=D and exp_rco<=0, then moves to TRACK. All other edges are ignored.
  - TRACK: on every edge:
    1. Compare the sampled Q with exp_Q and the sampled rco with exp_rco. These model values were produced at the previous edge.
    2. Increment check_count.
    3. On a mismatch, raise err (plus err_q and/or err_rco) for exactly one cycle, set err_sticky, and increment err_count.
    4. Update exp_Q and exp_rco from the enb/modo/D sampled at this edge.
  - Compare and model update happen on the same edge.
  - Model never resyncs to the DUT: after a Q mismatch, the model continues from its own exp_Q, not from the DUT's Q.
  - TRACK -> HALT when STOP_ON_ERR=1 and a mismatch occurs on this edge. Otherwise the FSM stays in TRACK.
  - HALT: exp_Q, both counters and err_sticky are frozen. Pulse outputs are 0. Only reset exits HALT.
- Latency: err pulses are registered. They are visible in the cycle after the edge on which the mismatching Q/rco was sampled.
- Saturation: err_count and check_count stop at 2^CNT_W-1 and never wrap.
- Load in TRACK: modo=11 with enb=1 reloads exp_Q from D (re-anchor) and the normal compare still happens on that edge.
- enb=0 in TRACK: compares still occur and check_count still increments.
- Reset mid-TRACK or mid-HALT: returns to UNSYNC and clears all counters. A new load is needed before checking resumes.
- Arithmetic is in WIDTH bits with natural wrap. There is no X propagation handling; X on Q counts as a mismatch.

Test Plan:
1. Reset. Load D=4'h5 (modo=11, enb=1). Then 3 edges with modo=00 and a correct DUT -> Q 6,7,8; err never 1; check_count=3; err_count=0.
2. Load 4'hF, then modo=00 -> checker expects Q=0 with rco=1. A correct DUT gives no error. With the DUT rco forced to 0 -> err and err_rco pulse for 1 cycle; err_q=0; err_count=1; err_sticky=1.
3. Load 4'h1, then modo=10 -> exp_Q=4'hE, rco=1. Next modo=01 -> exp_Q=4'hD, rco=0. Force Q=4'hC on that edge -> err_q pulse; the model continues from 4'hD.
4. enb=0 for 4 edges after load 4'h9 -> exp_Q stays 9; rco expected 0; check_count advances by 4.
5. STOP_ON_ERR=1. Inject one Q mismatch -> HALT. Next 5 edges: check_count and err_count frozen; err=0; synced=1.
6. Assert reset mid-TRACK, release, then drive modo=00 without a load -> synced=0, counters stay 0, no err. The first load re-enters TRACK.
